// File: rtl/fb_write_scheduler.sv
// Write-port sequencer for the scaled frame buffer: an optional clear sweep on
// each new frame, then the renderer's pixel stream over a valid/ready handshake.
module fb_write_scheduler #(
   parameter int unsigned FRAME_WIDTH  = 320,
   parameter int unsigned FRAME_HEIGHT = 180,
   parameter int unsigned ADDR_W       = $clog2(FRAME_WIDTH*FRAME_HEIGHT)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              new_frame_in,
   input  logic              clear_en_in,
   input  logic [15:0]       clear_color_in,
   input  logic              px_valid_in,
   output logic              px_ready_out,
   input  logic [ADDR_W-1:0] px_addr_in,
   input  logic [15:0]       px_data_in,
   output logic [ADDR_W-1:0] sbuf_w_addr_out,
   output logic              sbuf_w_valid_out,
   output logic [15:0]       sbuf_w_data_out,
   output logic              clearing_out,
   output logic              clear_done_out,
   output logic              overrun_out
);

   localparam int unsigned       N    = FRAME_WIDTH * FRAME_HEIGHT;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, RENDER} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [15:0]       color_q;
   logic [ADDR_W-1:0] w_addr_q;
   logic [15:0]       w_data_q;
   logic              w_valid_q;
   logic              clear_done_q;
   logic              overrun_q;

   // Ready and clearing are pure decodes of the registered state.
   assign px_ready_out     = (state_q == RENDER);
   assign clearing_out     = (state_q == CLEAR);
   assign sbuf_w_addr_out  = w_addr_q;
   assign sbuf_w_data_out  = w_data_q;
   assign sbuf_w_valid_out = w_valid_q;
   assign clear_done_out   = clear_done_q;
   assign overrun_out      = overrun_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         color_q      <= '0;
         w_addr_q     <= '0;
         w_data_q     <= '0;
         w_valid_q    <= 1'b0;
         clear_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         w_valid_q    <= 1'b0;
         clear_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (new_frame_in) begin
                  if (clear_en_in) begin
                     state_q <= CLEAR;
                     cnt_q   <= '0;
                     color_q <= clear_color_in;
                  end else begin
                     state_q <= RENDER;
                  end
               end
            end
            CLEAR: begin
               w_valid_q <= 1'b1;
               w_addr_q  <= cnt_q;
               w_data_q  <= color_q;
               // A frame start mid-sweep is flagged but never restarts the sweep.
               overrun_q <= new_frame_in;
               if (cnt_q == LAST) begin
                  state_q      <= RENDER;
                  clear_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RENDER: begin
               // Out-of-range pixels are handshaken but dropped.
               if (px_valid_in && (px_addr_in <= LAST)) begin
                  w_valid_q <= 1'b1;
                  w_addr_q  <= px_addr_in;
                  w_data_q  <= px_data_in;
               end
               if (new_frame_in && clear_en_in) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  color_q <= clear_color_in;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Randomised scoreboard bench for fb_write_scheduler on a reduced 32x18 buffer
// so that several full clear sweeps fit in a short run.
module tb_fb_write_scheduler;

   localparam int unsigned W  = 32;
   localparam int unsigned H  = 18;
   localparam int unsigned N  = W * H;
   localparam int unsigned AW = $clog2(N);

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          new_frame_in;
   logic          clear_en_in;
   logic [15:0]   clear_color_in;
   logic          px_valid_in;
   logic          px_ready_out;
   logic [AW-1:0] px_addr_in;
   logic [15:0]   px_data_in;
   logic [AW-1:0] sbuf_w_addr_out;
   logic          sbuf_w_valid_out;
   logic [15:0]   sbuf_w_data_out;
   logic          clearing_out;
   logic          clear_done_out;
   logic          overrun_out;

   fb_write_scheduler #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ADDR_W(AW)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .new_frame_in     (new_frame_in),
      .clear_en_in      (clear_en_in),
      .clear_color_in   (clear_color_in),
      .px_valid_in      (px_valid_in),
      .px_ready_out     (px_ready_out),
      .px_addr_in       (px_addr_in),
      .px_data_in       (px_data_in),
      .sbuf_w_addr_out  (sbuf_w_addr_out),
      .sbuf_w_valid_out (sbuf_w_valid_out),
      .sbuf_w_data_out  (sbuf_w_data_out),
      .clearing_out     (clearing_out),
      .clear_done_out   (clear_done_out),
      .overrun_out      (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [15:0]   d;
      logic          done;
   } wr_t;

   wr_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   // Reference model: remaining clear writes, whether the port is granted to
   // the renderer, the colour of the sweep in progress, the pending overrun pulse.
   int          clear_left = 0;
   bit          rendering  = 0;
   logic [15:0] m_col      = '0;
   bit          exp_ov     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int a, input logic [15:0] d, input bit done);
      wr_t e;
      e.a = AW'(a);
      e.d = d;
      e.done = done;
      sb.push_back(e);
   endtask

   // Monitor: every write the buffer sees must be the oldest expected one.
   always @(negedge clk_in) begin
      if (rst_n_in && sbuf_w_valid_out) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {sbuf_w_addr_out, sbuf_w_data_out}, '0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("write", {sbuf_w_addr_out, sbuf_w_data_out, clear_done_out},
                {e.a, e.d, e.done});
         end
      end else if (clear_done_out) begin
         chk("clear_done_without_write", 64'(clear_done_out), 64'd0);
      end
   end

   // One clock cycle: called #1 after a rising edge, returns #1 after the next.
   task automatic step(input bit nf, input bit ce, input logic [15:0] col,
                       input bit pv, input int pa, input logic [15:0] pd);
      new_frame_in   = nf;
      clear_en_in    = ce;
      clear_color_in = col;
      px_valid_in    = pv;
      px_addr_in     = AW'(pa);
      px_data_in     = pd;
      chk("px_ready", 64'(px_ready_out), 64'(rendering));
      chk("clearing", 64'(clearing_out), 64'(clear_left > 0));
      chk("overrun", 64'(overrun_out), 64'(exp_ov));
      exp_ov = 0;
      if (clear_left > 0) begin
         push(N - clear_left, m_col, clear_left == 1);
         exp_ov = nf;
         clear_left--;
         if (clear_left == 0) rendering = 1;
      end else if (rendering) begin
         if (pv && pa < N) push(pa, pd, 0);
         if (nf && ce) begin
            clear_left = N;
            m_col      = col;
            rendering  = 0;
         end
      end else if (nf) begin
         if (ce) begin
            clear_left = N;
            m_col      = col;
         end else begin
            rendering = 1;
         end
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
   endtask

   task automatic rand_px(input int n, input int max_addr);
      for (int i = 0; i < n; i++)
         step(0, 0, '0, 1'($urandom_range(0, 1)), int'($urandom_range(0, max_addr)),
              16'($urandom));
   endtask

   // Reset asserted #1 after an edge; outputs must drop without waiting for a clock.
   task automatic do_reset();
      rst_n_in = 1'b0;
      #1;
      chk("reset_outputs",
          {sbuf_w_addr_out, sbuf_w_data_out, sbuf_w_valid_out, px_ready_out,
           clearing_out, clear_done_out, overrun_out}, '0);
      sb.delete();
      clear_left = 0;
      rendering  = 0;
      exp_ov     = 0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   initial begin
      new_frame_in   = 0;
      clear_en_in    = 0;
      clear_color_in = '0;
      px_valid_in    = 0;
      px_addr_in     = '0;
      px_data_in     = '0;
      @(posedge clk_in);
      #1;
      do_reset();
      idle(3);

      // Full clear sweep with pixel requests that must be ignored meanwhile.
      step(1, 1, 16'hAE5D, 0, 0, '0);
      for (int i = 0; i < N; i++) step(0, 0, '0, 1, i % N, 16'h1234);
      idle(2);

      // Single pixel, then back-to-back random pixels.
      step(0, 0, '0, 1, 100, 16'hF800);
      for (int i = 0; i < 20; i++) step(0, 0, '0, 1, int'($urandom_range(0, N - 1)), 16'($urandom));
      rand_px(40, N - 1);

      // new_frame without clear from RENDER, with a same-cycle handshake.
      step(1, 0, 16'h0F0F, 1, 7, 16'h0707);
      rand_px(10, N - 1);

      // new_frame without clear from IDLE.
      do_reset();
      idle(2);
      step(1, 0, 16'hFFFF, 0, 0, '0);
      rand_px(20, N - 1);

      // Out-of-range addresses are accepted but not written.
      step(0, 0, '0, 1, N, 16'hDEAD);
      step(0, 0, '0, 1, (1 << AW) - 1, 16'hBEEF);
      step(0, 0, '0, 1, N - 1, 16'h5A5A);
      rand_px(30, (1 << AW) - 1);

      // Overrun: second new_frame mid-sweep with a different colour.
      step(1, 1, 16'h1357, 1, 3, 16'h3333);
      for (int i = 0; i < N + 3; i++) begin
         if (i == 300) step(1, 1, 16'h2468, 0, 0, '0);
         else          step(0, 0, '0, 1, 5, 16'h5555);
      end
      rand_px(20, N - 1);

      // Reset mid-sweep, then stay idle until the next new_frame.
      step(1, 1, 16'h00FF, 0, 0, '0);
      for (int i = 0; i < 200; i++) step(0, 0, '0, 0, 0, '0);
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 1, 16'hAAAA, 1, i, 16'h4444);
      step(1, 1, 16'h0F0F, 0, 0, '0);
      for (int i = 0; i < N + 2; i++) step(0, 0, '0, 0, 0, '0);

      // Mixed random traffic including frame starts at arbitrary points.
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << AW) - 1)), 16'($urandom));
      while (clear_left > 0) step(0, 0, '0, 0, 0, '0);
      idle(4);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
